// File: rtl/pattern_detect_pkg.sv
// Shared constants and types for the serial pattern detector.
// Holds the overlap mode encodings, the fill FSM states and the default pattern set.
package pattern_detect_pkg;

  localparam logic MODE_OVERLAP    = 1'b1;
  localparam logic MODE_NONOVERLAP = 1'b0;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } fill_state_e;

  localparam int unsigned DEF_PATTERN_LEN  = 3;
  localparam int unsigned DEF_NUM_PATTERNS = 2;

  // Pattern k lives at bits [k*PATTERN_LEN +: PATTERN_LEN]: pattern0 = 111, pattern1 = 001.
  localparam logic [DEF_PATTERN_LEN*DEF_NUM_PATTERNS-1:0] DEFAULT_PATTERNS_C = {3'b001, 3'b111};

  function automatic int unsigned idx_width(input int unsigned n);
    if (n > 1) return $clog2(n);
    return 1;
  endfunction

endpackage

// File: rtl/pattern_match_slice.sv
// One pattern lane: programmable pattern register, window compare,
// registered match pulse and a saturating match counter.
module pattern_match_slice
  import pattern_detect_pkg::*;
#(
  parameter int unsigned           PATTERN_LEN   = 3,
  parameter int unsigned           COUNT_W       = 8,
  parameter logic [PATTERN_LEN-1:0] RESET_PATTERN = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   compare_en,
  input  logic [PATTERN_LEN-1:0] window,
  input  logic                   we,
  input  logic [PATTERN_LEN-1:0] cfg_pattern,
  output logic                   hit_c,
  output logic                   match,
  output logic [COUNT_W-1:0]     count
);

  logic [PATTERN_LEN-1:0] pattern;

  // Compare uses the register's current value, so a same-cycle write only affects later bits.
  assign hit_c = compare_en && (window == pattern);

  // Pattern register survives clear; only reset or a config write changes it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pattern <= RESET_PATTERN;
    end else if (we) begin
      pattern <= cfg_pattern;
    end
  end

  // Match pulse and counter; a write to this lane beats a coincident match increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      match <= 1'b0;
      count <= '0;
    end else if (clear) begin
      match <= 1'b0;
      count <= '0;
    end else begin
      match <= hit_c;
      if (we) begin
        count <= '0;
      end else if (hit_c && (count != {COUNT_W{1'b1}})) begin
        count <= count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial bit-pattern detector: shifts in qualified bits and flags every
// programmable pattern that the newest PATTERN_LEN-bit window matches.
module serial_pattern_detector
  import pattern_detect_pkg::*;
#(
  parameter int unsigned PATTERN_LEN  = 3,
  parameter int unsigned NUM_PATTERNS = 2,
  parameter int unsigned COUNT_W      = 8,
  parameter logic [PATTERN_LEN*NUM_PATTERNS-1:0] DEFAULT_PATTERNS =
    (PATTERN_LEN*NUM_PATTERNS)'(DEFAULT_PATTERNS_C),
  localparam int unsigned IDX_W = idx_width(NUM_PATTERNS)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic                            in_bit,
  input  logic                            overlap,
  input  logic                            cfg_we,
  input  logic [IDX_W-1:0]                cfg_idx,
  input  logic [PATTERN_LEN-1:0]          cfg_pattern,
  output logic [NUM_PATTERNS-1:0]         match,
  output logic [NUM_PATTERNS*COUNT_W-1:0] match_count
);

  localparam int unsigned         FILL_W    = $clog2(PATTERN_LEN + 1);
  localparam logic [FILL_W-1:0]   FILL_LAST = FILL_W'(PATTERN_LEN - 1);

  // The incoming bit completes the window, so only the PATTERN_LEN-1 older bits are stored.
  logic [PATTERN_LEN-2:0]  history, history_next;
  logic [FILL_W-1:0]       fill, fill_next;
  fill_state_e             state, state_next;
  logic [PATTERN_LEN-1:0]  window_c;
  logic [NUM_PATTERNS-1:0] hit_c;
  logic                    accept_c;
  logic                    compare_en_c;
  logic                    restart_c;

  assign accept_c     = in_valid && !clear;
  assign window_c     = {history, in_bit};
  assign compare_en_c = accept_c && ((state == ARMED) || (fill == FILL_LAST));

  // In non-overlapping mode any lane hit restarts the fill, once regardless of hit count.
  always_comb begin
    restart_c = 1'b0;
    case (overlap)
      MODE_OVERLAP:    restart_c = 1'b0;
      MODE_NONOVERLAP: restart_c = |hit_c;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FILLING;
      fill    <= '0;
      history <= '0;
    end else begin
      state   <= state_next;
      fill    <= fill_next;
      history <= history_next;
    end
  end

  // Fill FSM next-state and history update.
  always_comb begin
    state_next   = state;
    fill_next    = fill;
    history_next = history;
    if (clear) begin
      state_next   = FILLING;
      fill_next    = '0;
      history_next = '0;
    end else if (in_valid) begin
      if (restart_c) begin
        state_next   = FILLING;
        fill_next    = '0;
        history_next = '0;
      end else begin
        history_next = window_c[PATTERN_LEN-2:0];
        if (state == FILLING) begin
          fill_next = fill + FILL_W'(1);
          if (fill == FILL_LAST) begin
            state_next = ARMED;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_PATTERNS; k++) begin : g_slice
    pattern_match_slice #(
      .PATTERN_LEN  (PATTERN_LEN),
      .COUNT_W      (COUNT_W),
      .RESET_PATTERN(DEFAULT_PATTERNS[k*PATTERN_LEN +: PATTERN_LEN])
    ) u_slice (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (clear),
      .compare_en (compare_en_c),
      .window     (window_c),
      .we         (cfg_we && (cfg_idx == IDX_W'(k))),
      .cfg_pattern(cfg_pattern),
      .hit_c      (hit_c[k]),
      .match      (match[k]),
      .count      (match_count[k*COUNT_W +: COUNT_W])
    );
  end

endmodule

// File: doc/serial_pattern_detector.md
# serial_pattern_detector

Parametrised serial bit-pattern detector: samples one bit per qualified clock, compares the last `PATTERN_LEN` bits against `NUM_PATTERNS` runtime-programmable patterns, and reports every match on a registered one-hot-per-pattern output. It supports overlapping and non-overlapping match modes, per-pattern saturating match counters and a fill guard that suppresses matches until the history is full. It sits directly on a serial input stream as the generalised detector stage in the exercise designs.

## Interface
Parameters:
- `PATTERN_LEN`, 3: bits per pattern, ≥2; pattern MSB = oldest bit.
- `NUM_PATTERNS`, 2: number of patterns, ≥1.
- `COUNT_W`, 8: width of each match counter.
- `DEFAULT_PATTERNS`, {3'b001, 3'b111}: reset value of the pattern registers, flat; pattern k at bits [k*PATTERN_LEN +: PATTERN_LEN].

Ports:
- `clock`  in  1  single clock; everything sampled on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear of history, fill and counters.
- `in_valid`  in  1  qualifies `in_bit`.
- `in_bit`  in  1  serial data bit.
- `overlap`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `cfg_we`  in  1  pattern write strobe.
- `cfg_idx`  in  $clog2(NUM_PATTERNS) (min 1)  pattern index to write.
- `cfg_pattern`  in  PATTERN_LEN  new pattern value.
- `match`  out  NUM_PATTERNS  bit k = pattern k matched, one-cycle pulse.
- `match_count`  out  NUM_PATTERNS*COUNT_W  flat saturating per-pattern counters.

## Operation
- History: `PATTERN_LEN`-bit shift register. Each accepted bit shifts in at the LSB.
- Fill FSM: FILLING (fill counter < PATTERN_LEN) → ARMED once PATTERN_LEN bits are present. Compares happen only when the window including the current bit is full, i.e. fill ≥ PATTERN_LEN-1 before the shift.
- Match k: the accepted bit completes a window equal to pattern k. All matching patterns flag in the same cycle.
- Overlap=1: history is kept after a match.
- Overlap=0: any match clears history and sets fill to 0, returning the FSM to FILLING. This happens once, even when several patterns match.
- `overlap` is sampled per accepted bit and may change at any time.
- Counter k increments on each match k and saturates at all-ones.
- Config write with `cfg_we`=1: pattern[cfg_idx] ← cfg_pattern, and counter[cfg_idx] ← 0. History is unaffected. Writes with `cfg_idx` ≥ NUM_PATTERNS are ignored.
- A bit accepted in the same cycle as a write is compared against the old pattern. The new pattern applies from the next accepted bit.
- If a write and a match on the same index coincide, the write wins and the counter becomes 0.
- `clear` zeroes history, fill, `match` and all counters. Patterns are kept.
- If `clear` and `in_valid` coincide, clear wins and the bit is dropped.
- `in_valid`=0: no shift. `match` returns to 0.

## Timing
- Reset (async, takes effect immediately): history 0, fill 0, FSM FILLING, `match` 0, all counters 0, patterns = DEFAULT_PATTERNS.
- Latency: bit accepted at edge n → `match` high during cycle n..n+1 (registered Mealy output). The counter updates at the same edge.
- `match` is high for exactly one cycle per matching accepted bit. With back-to-back overlapping matches it stays high on consecutive cycles.
- Reset asserted mid-stream discards the partial history. After release, a full PATTERN_LEN bits are required before any match.

## Structure
- Package `pattern_detect_pkg`: constants `MODE_OVERLAP`/`MODE_NONOVERLAP`, fill-FSM state enum (`FILLING`, `ARMED`), default-pattern constant.
- Sub-module `pattern_match_slice`, one per pattern via generate. It holds the pattern register, window compare, registered match bit, and the saturating counter with write/clear priority.
- Top level holds the shift register, fill FSM, overlap clear logic and output flattening.

## Test plan
Defaults unless stated: pattern0=111, pattern1=001.
- Reset, overlap=1, stream 1,1,1,1 → `match`=01 after bits 3 and 4; count0=2.
- overlap=0, stream 1×6 → `match`=01 after bits 3 and 6 only; count0=2, count1=0.
- Fill guard: stream 1,1 → no match. Then 0,0,1 → `match`=10 after the fifth bit; count1=1.
- Write idx0=010 with a counter at 2 → count0=0. Stream 0,1,0 → `match`=01. A bit sent in the write cycle still uses 111.
- COUNT_W=2, 5 overlapping matches of 111 → count0 saturates at 3. `clear` → counters 0; patterns unchanged.
- reset_n low after 1,1 → `match`=0 and counters 0 immediately. After release, a single 1 → no match. 1,1,1 → match.
